// File: rtl/feature_flatten_buffer.sv
// feature_flatten_buffer: collects N_PIX signed pixels into a frame buffer and holds it for the FC layer. Inputs: clk, rst (async, active-low), pixel valid/sof/data, fc_done, clear_err. Outputs: ready, flattened buffer, fc_start, sof/drop error flags, frame count.
module feature_flatten_buffer #(
  parameter int N_PIX  = 225,
  parameter int DATA_W = 22
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_pixel_valid,
  input  logic                     i_pixel_sof,
  input  logic signed [DATA_W-1:0] i_pixel_data,
  output logic                     o_ready,
  output logic signed [DATA_W-1:0] o_flattened_data [0:N_PIX-1],
  output logic                     o_fc_start,
  input  logic                     i_fc_done,
  input  logic                     i_clear_err,
  output logic                     o_sof_err,
  output logic                     o_drop_err,
  output logic [15:0]              o_frame_cnt
);
  localparam int PW = N_PIX > 1 ? $clog2(N_PIX) : 1;
  localparam logic [PW-1:0] LAST = PW'(N_PIX - 1);
  typedef enum logic {FILL, LOCKED} state_t;
  state_t state, state_nx;
  logic [PW-1:0] wr_ptr, wr_ptr_nx, wr_addr;
  logic accept, last;
  assign accept = i_pixel_valid && o_ready;
  assign last = accept && !i_pixel_sof && wr_ptr == LAST;
  assign wr_addr = i_pixel_sof ? '0 : wr_ptr;
  assign wr_ptr_nx = !accept ? wr_ptr : i_pixel_sof ? PW'(1) : wr_ptr == LAST ? '0 : wr_ptr + 1'b1;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= FILL;
    else state <= state_nx;
  always_comb state_nx = state == FILL ? (last ? LOCKED : FILL) : (i_fc_done ? FILL : LOCKED);
  always_comb begin
    o_ready = state == FILL;
    o_fc_start = state == LOCKED;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_ptr <= '0;
      o_frame_cnt <= '0;
      o_sof_err <= 1'b0;
      o_drop_err <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr_nx;
      o_frame_cnt <= o_frame_cnt + {15'd0, last};
      o_sof_err <= (accept && i_pixel_sof && wr_ptr != '0) || (o_sof_err && !i_clear_err);
      o_drop_err <= (i_pixel_valid && state == LOCKED) || (o_drop_err && !i_clear_err);
    end
  always_ff @(posedge clk or negedge rst)
    if (!rst) for (int i = 0; i < N_PIX; i++) o_flattened_data[i] <= '0;
    else if (accept) o_flattened_data[wr_addr] <= i_pixel_data;
endmodule

// File: tb/tb_feature_flatten_buffer.sv
// tb_feature_flatten_buffer: directed self-checking bench for feature_flatten_buffer.
module tb_feature_flatten_buffer;
  localparam int N = 225;
  localparam int W = 22;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic valid = 1'b0, sof = 1'b0, fc_done = 1'b0, clear_err = 1'b0;
  logic signed [W-1:0] data = '0;
  logic ready, fc_start, sof_err, drop_err;
  logic [15:0] frame_cnt;
  logic signed [W-1:0] flat [0:N-1];
  logic signed [W-1:0] exp_buf [0:N-1];
  int ptr = 0;
  int errors = 0;
  int checks = 0;
  feature_flatten_buffer #(.N_PIX(N), .DATA_W(W)) dut (
    .clk(clk), .rst(rst), .i_pixel_valid(valid), .i_pixel_sof(sof), .i_pixel_data(data),
    .o_ready(ready), .o_flattened_data(flat), .o_fc_start(fc_start), .i_fc_done(fc_done),
    .i_clear_err(clear_err), .o_sof_err(sof_err), .o_drop_err(drop_err), .o_frame_cnt(frame_cnt)
  );
  always #5 clk = ~clk;
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_buf(input string tag);
    int bad = 0;
    for (int k = 0; k < N; k++) if (flat[k] !== exp_buf[k]) bad++;
    chk(tag, 64'(bad), 64'd0);
  endtask
  task automatic clr_model;
    for (int k = 0; k < N; k++) exp_buf[k] = '0;
    ptr = 0;
  endtask
  task automatic send(input logic signed [W-1:0] d, input logic s);
    valid = 1'b1;
    sof = s;
    data = d;
    step;
    if (s) ptr = 0;
    exp_buf[ptr] = d;
    ptr = s ? 1 : (ptr == N - 1 ? 0 : ptr + 1);
    valid = 1'b0;
    sof = 1'b0;
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_ready"}, 64'(ready), 64'd1);
    chk({tag, "_start"}, 64'(fc_start), 64'd0);
    chk({tag, "_errs"}, 64'({sof_err, drop_err}), 64'd0);
    chk({tag, "_cnt"}, 64'(frame_cnt), 64'd0);
    chk_buf({tag, "_buf"});
  endtask
  initial begin
    clr_model();
    step;
    step;
    chk_reset("rst0");
    rst = 1'b1;
    for (int k = 0; k < N - 1; k++) send(W'(k), k == 0);
    chk("f1_start_early", 64'(fc_start), 64'd0);
    chk("f1_ready_early", 64'(ready), 64'd1);
    send(W'(N - 1), 1'b0);
    chk("f1_start", 64'(fc_start), 64'd1);
    chk("f1_ready", 64'(ready), 64'd0);
    chk("f1_cnt", 64'(frame_cnt), 64'd1);
    chk_buf("f1_buf");
    valid = 1'b1;
    data = W'(999);
    step;
    step;
    step;
    chk("lock_drop", 64'(drop_err), 64'd1);
    chk("lock_start", 64'(fc_start), 64'd1);
    chk_buf("lock_buf");
    fc_done = 1'b1;
    step;
    fc_done = 1'b0;
    valid = 1'b0;
    chk("done_start", 64'(fc_start), 64'd0);
    chk("done_ready", 64'(ready), 64'd1);
    chk("done_drop", 64'(drop_err), 64'd1);
    chk_buf("done_buf");
    fc_done = 1'b1;
    step;
    fc_done = 1'b0;
    chk("done_in_fill", 64'(ready), 64'd1);
    chk("done_in_fill_cnt", 64'(frame_cnt), 64'd1);
    clear_err = 1'b1;
    step;
    clear_err = 1'b0;
    chk("clr_flags", 64'({sof_err, drop_err}), 64'd0);
    for (int k = 0; k < 100; k++) send(W'(1000 + k), k == 0);
    chk("pre_sof_err", 64'(sof_err), 64'd0);
    send(-W'(5), 1'b1);
    chk("sof_err", 64'(sof_err), 64'd1);
    chk("sof_entry0", 64'(flat[0]), 64'(-5));
    for (int k = 1; k < N - 1; k++) send(W'(-k), 1'b0);
    chk("sof_start_early", 64'(fc_start), 64'd0);
    send(W'(77), 1'b0);
    chk("sof_start", 64'(fc_start), 64'd1);
    chk("sof_cnt", 64'(frame_cnt), 64'd2);
    chk_buf("sof_buf");
    fc_done = 1'b1;
    step;
    fc_done = 1'b0;
    clear_err = 1'b1;
    step;
    clear_err = 1'b0;
    for (int k = 0; k < N; k++) begin
      for (int g = $urandom_range(0, 3); g > 0; g--) step;
      if (k == N - 1) chk("gap_start_early", 64'(fc_start), 64'd0);
      send(W'(3 * k - 300), 1'b0);
    end
    chk("gap_start", 64'(fc_start), 64'd1);
    chk("gap_cnt", 64'(frame_cnt), 64'd3);
    chk("gap_sof_err", 64'(sof_err), 64'd0);
    chk_buf("gap_buf");
    valid = 1'b1;
    clear_err = 1'b1;
    step;
    chk("clr_vs_drop", 64'(drop_err), 64'd1);
    valid = 1'b0;
    step;
    clear_err = 1'b0;
    chk("clr_alone", 64'({sof_err, drop_err}), 64'd0);
    fc_done = 1'b1;
    step;
    fc_done = 1'b0;
    for (int k = 0; k < 150; k++) send(W'(k + 5), k == 0);
    rst = 1'b0;
    clr_model();
    #1;
    chk_reset("rst_mid");
    step;
    rst = 1'b1;
    for (int k = 0; k < N; k++) send(W'(2 * k), k == 0);
    chk("pre_rst_lock", 64'(fc_start), 64'd1);
    rst = 1'b0;
    clr_model();
    #1;
    chk_reset("rst_lock");
    step;
    rst = 1'b1;
    for (int k = 0; k < N; k++) send(W'(N - k), k == 0);
    chk("post_rst_start", 64'(fc_start), 64'd1);
    chk("post_rst_cnt", 64'(frame_cnt), 64'd1);
    chk_buf("post_rst_buf");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/feature_flatten_buffer.md
FEATURE_FLATTEN_BUFFER -- requirements
Module: feature_flatten_buffer

Interface
REQ-001 SHALL have parameter N_PIX, default 225, meaning the number of feature-map entries per frame (15x15).
REQ-002 SHALL have parameter DATA_W, default 22, meaning the signed width of each entry.
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_pixel_valid  input  1  upstream pixel qualifier.
REQ-006 SHALL have port i_pixel_sof  input  1  start-of-frame marker, meaningful only with i_pixel_valid.
REQ-007 SHALL have port i_pixel_data  input  DATA_W signed  pixel value from the pooling stage.
REQ-008 SHALL have port o_ready  output  1  high when a pixel presented this cycle is accepted.
REQ-009 SHALL have port o_flattened_data  output  array [0:N_PIX-1] of DATA_W signed  registered frame buffer feeding the FC layer.
REQ-010 SHALL have port o_fc_start  output  1  level start request to the FC layer.
REQ-011 SHALL have port i_fc_done  input  1  single-cycle FC result-valid pulse.
REQ-012 SHALL have port i_clear_err  input  1  synchronous clear of the sticky error flags.
REQ-013 SHALL have port o_sof_err  output  1  sticky flag for a mid-frame SOF.
REQ-014 SHALL have port o_drop_err  output  1  sticky flag for a pixel offered while locked.
REQ-015 SHALL have port o_frame_cnt  output  16  count of frames handed to the FC layer.

Function
REQ-016 SHALL implement two states: FILL and LOCKED, with an internal write pointer wr_ptr of range 0..N_PIX-1.
REQ-017 SHALL drive o_ready = (state == FILL) combinationally from state only; o_ready SHALL NOT depend on i_pixel_valid.
REQ-018 SHALL accept a pixel when i_pixel_valid && o_ready, and write i_pixel_data into o_flattened_data[wr_ptr] at that edge.
REQ-019 SHALL increment wr_ptr by 1 on each accept without SOF when wr_ptr < N_PIX-1.
REQ-020 SHALL, on an accept with i_pixel_sof=1, write entry 0 and set wr_ptr=1; if wr_ptr was nonzero, the partial frame is discarded and o_sof_err is set.
REQ-021 SHALL treat an accept with wr_ptr==0 and i_pixel_sof=0 as a normal entry-0 write without error.
REQ-022 SHALL, on an accept with wr_ptr==N_PIX-1 and no SOF, go to LOCKED, reset wr_ptr to 0, and increment o_frame_cnt, wrapping from 0xFFFF to 0.
REQ-023 SHALL hold o_fc_start=1 throughout LOCKED and 0 in FILL; o_fc_start rises one cycle after the last write edge.
REQ-024 SHALL keep o_flattened_data unchanged for the whole of LOCKED, because the FC layer reads it by index during computation.
REQ-025 SHALL, in LOCKED, return to FILL on i_fc_done=1; o_fc_start falls and o_ready rises one cycle later.
REQ-026 SHALL ignore i_fc_done while in FILL.
REQ-027 SHALL set o_drop_err when i_pixel_valid=1 in LOCKED, including the cycle in which i_fc_done=1; the pixel is discarded.
REQ-028 SHALL clear o_sof_err and o_drop_err on i_clear_err=1; a set condition in the same cycle SHALL win.
REQ-029 SHALL guarantee that o_fc_start is low for at least N_PIX-1 cycles between frames, so that the FC rising-edge detector sees every frame.

Reset
REQ-030 SHALL, while rst=0, force state=FILL, wr_ptr=0, all o_flattened_data entries=0, o_fc_start=0, o_sof_err=0, o_drop_err=0, o_frame_cnt=0; o_ready=1.
REQ-031 SHALL, on reset asserted mid-frame or in LOCKED, discard all contents, with normal operation from the first edge after release.

Verification
REQ-032 SHALL cover: 225 back-to-back valid pixels, value k at index k, first one with SOF -> o_flattened_data[k]=k, o_fc_start=1 one cycle after pixel 224, o_frame_cnt=1, o_ready=0.
REQ-033 SHALL cover: in LOCKED, drive i_pixel_valid for 3 cycles, then i_fc_done pulse -> buffer unchanged, o_drop_err=1, next cycle o_fc_start=0 and o_ready=1.
REQ-034 SHALL cover: SOF at wr_ptr=100 with data -5 -> entry 0 = -5, wr_ptr=1, o_sof_err=1; 224 more pixels are needed before o_fc_start.
REQ-035 SHALL cover: valid pixels with random gaps of 0-3 cycles -> o_fc_start rises only after the 225th accept, with no lost or duplicated entries.
REQ-036 SHALL cover: rst pulsed low at wr_ptr=150 and again in LOCKED -> all outputs at reset values; a following full frame completes normally with o_frame_cnt=1.
REQ-037 SHALL cover: i_clear_err coincident with a new drop -> o_drop_err remains 1; i_clear_err alone -> both flags 0.
